// File: rtl/spi_main.sv
// SPI main, mode 0 (MSB first, sample on sck rise, change on sck fall, cs active low).
// One word per accepted start; keep_cs chains words into a burst without releasing cs.
module spi_main #(
  parameter int WordBits   = 8,
  parameter int HalfPeriod = 4,
  parameter int CsSetup    = 2,
  parameter int CsHold     = 2,
  parameter int CsIdle     = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                keep_cs,
  input  logic                cs_release,
  input  logic [WordBits-1:0] data_word_to_send,
  output logic [WordBits-1:0] data_word_received,
  output logic                busy,
  output logic                done,
  output logic                sck,
  output logic                out_bit,
  input  logic                in_bit,
  output logic                cs
);

  // The hold phase also covers the final sck-low half period, so the last bit
  // gets a full-width low phase before cs may rise.
  localparam int HoldLen = HalfPeriod + CsHold;
  localparam int Max1    = (CsSetup > HoldLen) ? CsSetup : HoldLen;
  localparam int CntMax  = (Max1 > CsIdle) ? Max1 : CsIdle;
  localparam int CntW    = $clog2(CntMax);
  localparam int BitW    = $clog2(WordBits) + 1;

  localparam logic [CntW-1:0] SetupLast = CntW'(CsSetup - 1);
  localparam logic [CntW-1:0] HalfLast  = CntW'(HalfPeriod - 1);
  localparam logic [CntW-1:0] HoldLast  = CntW'(HoldLen - 1);
  localparam logic [CntW-1:0] IdleLast  = CntW'(CsIdle - 1);
  localparam logic [BitW-1:0] BitsAll   = BitW'(WordBits);

  typedef enum logic [2:0] {
    IDLE, SETUP, HIGH, LOW, HOLD, GAP, BURST
  } state_t;

  state_t              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [BitW-1:0]     bits_q, bits_d;
  logic [WordBits-1:0] sr_q, sr_d;
  logic [WordBits-1:0] rx_q, rx_d;
  logic                keep_q, keep_d;
  logic                sck_q, sck_d;
  logic                cs_q, cs_d;
  logic                out_bit_q, out_bit_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CntW'(1);
    bits_d    = bits_q;
    sr_d      = sr_q;
    rx_d      = rx_q;
    keep_d    = keep_q;
    sck_d     = sck_q;
    cs_d      = cs_q;
    out_bit_d = out_bit_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          sr_d      = data_word_to_send;
          keep_d    = keep_cs;
          cs_d      = 1'b0;
          out_bit_d = data_word_to_send[WordBits-1];
          busy_d    = 1'b1;
          bits_d    = '0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == SetupLast) begin
          cnt_d   = '0;
          sck_d   = 1'b1;
          sr_d    = {sr_q[WordBits-2:0], in_bit};
          bits_d  = bits_q + BitW'(1);
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (cnt_q == HalfLast) begin
          cnt_d = '0;
          sck_d = 1'b0;
          if (bits_q == BitsAll) begin
            state_d = HOLD;
          end else begin
            out_bit_d = sr_q[WordBits-1];
            state_d   = LOW;
          end
        end
      end
      LOW: begin
        if (cnt_q == HalfLast) begin
          cnt_d   = '0;
          sck_d   = 1'b1;
          sr_d    = {sr_q[WordBits-2:0], in_bit};
          bits_d  = bits_q + BitW'(1);
          state_d = HIGH;
        end
      end
      HOLD: begin
        if (cnt_q == HoldLast) begin
          cnt_d  = '0;
          rx_d   = sr_q;
          done_d = 1'b1;
          if (keep_q) begin
            busy_d  = 1'b0;
            state_d = BURST;
          end else begin
            cs_d    = 1'b1;
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (cnt_q == IdleLast) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      BURST: begin
        cnt_d = '0;
        // Release has priority so a burst can always be closed cleanly.
        if (cs_release) begin
          cs_d    = 1'b1;
          busy_d  = 1'b1;
          state_d = GAP;
        end else if (start) begin
          sr_d      = data_word_to_send;
          keep_d    = keep_cs;
          out_bit_d = data_word_to_send[WordBits-1];
          busy_d    = 1'b1;
          bits_d    = '0;
          state_d   = LOW;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bits_q    <= '0;
      sr_q      <= '0;
      rx_q      <= '0;
      keep_q    <= 1'b0;
      sck_q     <= 1'b0;
      cs_q      <= 1'b1;
      out_bit_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bits_q    <= bits_d;
      sr_q      <= sr_d;
      rx_q      <= rx_d;
      keep_q    <= keep_d;
      sck_q     <= sck_d;
      cs_q      <= cs_d;
      out_bit_q <= out_bit_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign data_word_received = rx_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign sck                = sck_q;
  assign out_bit            = out_bit_q;
  assign cs                 = cs_q;

endmodule
